slm_acq_sequencer_multi: RTL and testbench

- Parametrised next-generation SLM acquisition sequencer.
- Steps through N SLM images, optionally across M galvo positions, in a single pass or in continuous loop mode.
- Qualifies frames from the VGA frame-sync, issues millisecond-length camera and galvo trigger pulses, and supports abort, programmable settle frames and zero-configuration error reporting.
- Sits between the host settings registers and the VGA frame-buffer reader; oFRAME_ID selects the displayed image.

---
 rtl/slm_acq_sequencer_multi.sv | 377 +++++++++++++++++++++++++++++++++++++
 tb/tb_slm_acq_sequencer_multi.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slm_acq_sequencer_multi.sv
// slm_acq_sequencer_multi
//
// SLM acquisition sequencer. Steps through iNUM_IMAGES SLM images (optionally at
// each of iNUM_POSITIONS galvo positions), once or in a continuous loop. Frame-end
// events come from a dejittered VGA frame sync. Each image is preceded by a
// settle period (plus a galvo acknowledge in galvo mode) and a camera trigger,
// then displayed for iCYCLES_PER_IMAGE frames.
//
// Ports:
//   iCLK, iRST             clock, asynchronous active-high reset
//   iSTART                 start pulse, only honoured in IDLE
//   iMODE_GALVO/LOOP       mode bits, latched at start
//   iABORT                 abort request, forces IDLE from any busy state
//   iNUM_IMAGES            images per position
//   iCYCLES_PER_IMAGE      frames each image is displayed
//   iNUM_POSITIONS         galvo positions
//   iSETTLE_FRAMES         frame-end events before the camera fires (0 acts as 1)
//   iCAM_PULSE_MS          camera pulse length in ms
//   iGALVO_PULSE_MS        galvo pulse length in ms
//   iGALVO_ACK             galvo settled (level or pulse)
//   iVGA_FRAME_SYNC        raw frame sync
//   oCAMERA_TRIGGER        camera pulse
//   oGALVO_CHANGE_TRIGGER  galvo step pulse
//   oFRAME_ID              current image index (0 in IDLE)
//   oPOSITION_ID           current galvo position index (0 in IDLE)
//   oBUSY                  sequencer not in IDLE
//   oDONE                  one-cycle pulse on normal completion
//   oERR_ZERO_CFG          one-cycle pulse when a start is rejected
module slm_acq_sequencer_multi #(
    parameter int unsigned IMG_W       = 7,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned POS_W       = 32,
    parameter int unsigned PULSE_W     = 8,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned SYNC_FILTER = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic               iMODE_GALVO,
    input  logic               iMODE_LOOP,
    input  logic               iABORT,
    input  logic [IMG_W-1:0]   iNUM_IMAGES,
    input  logic [CYC_W-1:0]   iCYCLES_PER_IMAGE,
    input  logic [POS_W-1:0]   iNUM_POSITIONS,
    input  logic [3:0]         iSETTLE_FRAMES,
    input  logic [PULSE_W-1:0] iCAM_PULSE_MS,
    input  logic [PULSE_W-1:0] iGALVO_PULSE_MS,
    input  logic               iGALVO_ACK,
    input  logic               iVGA_FRAME_SYNC,
    output logic               oCAMERA_TRIGGER,
    output logic               oGALVO_CHANGE_TRIGGER,
    output logic [IMG_W-1:0]   oFRAME_ID,
    output logic [POS_W-1:0]   oPOSITION_ID,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oERR_ZERO_CFG
);

    localparam int unsigned MS_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLatch,
        StGalvoPulse,
        StSettle,
        StCamera,
        StDisplay,
        StNextImg,
        StNextPos,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Frame-sync filter: OR of the last SYNC_FILTER samples hides short low
    // glitches; a frame-end is the registered falling edge of that OR.
    // ------------------------------------------------------------------
    logic [SYNC_FILTER-1:0] sync_sh_q, sync_sh_d;
    logic                   filt;
    logic                   filt_q;
    logic                   fe_q;

    always_comb begin
        sync_sh_d    = sync_sh_q << 1;
        sync_sh_d[0] = iVGA_FRAME_SYNC;
    end

    assign filt = |sync_sh_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sync_sh_q <= '0;
            filt_q    <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            sync_sh_q <= sync_sh_d;
            filt_q    <= filt;
            fe_q      <= filt_q & ~filt;
        end
    end

    // ------------------------------------------------------------------
    // Latched settings
    // ------------------------------------------------------------------
    logic               latch_en;
    logic [IMG_W-1:0]   num_img_q;
    logic [CYC_W-1:0]   cycles_q;
    logic [POS_W-1:0]   num_pos_q;
    logic [3:0]         settle_q;
    logic [PULSE_W-1:0] cam_ms_q;
    logic [PULSE_W-1:0] galvo_ms_q;
    logic               mode_galvo_q;
    logic               mode_loop_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            num_img_q    <= '0;
            cycles_q     <= '0;
            num_pos_q    <= '0;
            settle_q     <= '0;
            cam_ms_q     <= '0;
            galvo_ms_q   <= '0;
            mode_galvo_q <= 1'b0;
            mode_loop_q  <= 1'b0;
        end else if (latch_en) begin
            num_img_q    <= iNUM_IMAGES;
            cycles_q     <= iCYCLES_PER_IMAGE;
            num_pos_q    <= iNUM_POSITIONS;
            settle_q     <= iSETTLE_FRAMES;
            cam_ms_q     <= iCAM_PULSE_MS;
            galvo_ms_q   <= iGALVO_PULSE_MS;
            mode_galvo_q <= iMODE_GALVO;
            mode_loop_q  <= iMODE_LOOP;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [IMG_W-1:0]   img_q, img_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [3:0]         settle_cnt_q, settle_cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               cam_start, galvo_start;
    logic               end_of_pass;

    logic               cfg_zero;
    logic [3:0]         settle_tgt;
    logic               settle_hit;
    logic               cyc_hit;
    logic               img_last;
    logic               pos_last;

    assign cfg_zero = (num_img_q == '0) || (cycles_q == '0) ||
                      (mode_galvo_q && (num_pos_q == '0));

    assign settle_tgt = (settle_q == 4'd0) ? 4'd1 : settle_q;

    // Settle is complete either already (counter saturated at target) or on
    // the frame-end that brings the count to the target.
    assign settle_hit = (settle_cnt_q == settle_tgt) ||
                        (fe_q && (({1'b0, settle_cnt_q} + 5'd1) == {1'b0, settle_tgt}));

    // Compares are one bit wider so count+1 never wraps.
    assign cyc_hit  = ({1'b0, cyc_q} + (CYC_W + 1)'(1)) == {1'b0, cycles_q};
    assign img_last = ({1'b0, img_q} + (IMG_W + 1)'(1)) == {1'b0, num_img_q};
    assign pos_last = ({1'b0, pos_q} + (POS_W + 1)'(1)) == {1'b0, num_pos_q};

    always_comb begin
        state_d      = state_q;
        img_d        = img_q;
        pos_d        = pos_q;
        cyc_d        = cyc_q;
        settle_cnt_d = settle_cnt_q;
        ack_d        = ack_q;
        err_d        = 1'b0;
        latch_en     = 1'b0;
        cam_start    = 1'b0;
        galvo_start  = 1'b0;
        end_of_pass  = 1'b0;

        unique case (state_q)
            StIdle: begin
                img_d = '0;
                pos_d = '0;
                cyc_d = '0;
                if (iSTART && !iABORT) begin
                    latch_en = 1'b1;
                    state_d  = StLatch;
                end
            end
            StLatch: begin
                if (cfg_zero) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = mode_galvo_q ? StGalvoPulse : StSettle;
                end
            end
            StGalvoPulse: begin
                galvo_start = 1'b1;
                ack_d       = iGALVO_ACK;
                state_d     = StSettle;
            end
            StSettle: begin
                if (fe_q && (settle_cnt_q != settle_tgt)) begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
                if (iGALVO_ACK) begin
                    ack_d = 1'b1;
                end
                if (settle_hit && (!mode_galvo_q || ack_q || iGALVO_ACK)) begin
                    state_d = StCamera;
                end
            end
            StCamera: begin
                cam_start = 1'b1;
                cyc_d     = '0;
                state_d   = StDisplay;
            end
            StDisplay: begin
                if (fe_q) begin
                    if (cyc_hit) begin
                        state_d = StNextImg;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
            end
            StNextImg: begin
                if (!img_last) begin
                    img_d   = img_q + IMG_W'(1);
                    state_d = StSettle;
                end else if (mode_galvo_q) begin
                    state_d = StNextPos;
                end else begin
                    end_of_pass = 1'b1;
                end
            end
            StNextPos: begin
                if (!pos_last) begin
                    pos_d   = pos_q + POS_W'(1);
                    img_d   = '0;
                    state_d = StGalvoPulse;
                end else begin
                    end_of_pass = 1'b1;
                end
            end
            StDone: begin
                img_d   = '0;
                pos_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (end_of_pass) begin
            if (mode_loop_q) begin
                img_d   = '0;
                pos_d   = '0;
                state_d = mode_galvo_q ? StGalvoPulse : StSettle;
            end else begin
                state_d = StDone;
            end
        end

        // Each settle period starts counting from zero.
        if ((state_d == StSettle) && (state_q != StSettle)) begin
            settle_cnt_d = '0;
        end

        // Abort wins over every other transition.
        if (iABORT && (state_q != StIdle)) begin
            state_d      = StIdle;
            img_d        = '0;
            pos_d        = '0;
            cyc_d        = '0;
            settle_cnt_d = '0;
            ack_d        = 1'b0;
            err_d        = 1'b0;
            cam_start    = 1'b0;
            galvo_start  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= StIdle;
            img_q        <= '0;
            pos_q        <= '0;
            cyc_q        <= '0;
            settle_cnt_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_q        <= img_d;
            pos_q        <= pos_d;
            cyc_q        <= cyc_d;
            settle_cnt_q <= settle_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse generators: index 0 = camera, 1 = galvo. Length is counted as
    // whole milliseconds of MS_CYC clocks; a start restarts the full length.
    // ------------------------------------------------------------------
    logic [1:0]               pg_start;
    logic                     pg_cancel;
    logic [1:0][PULSE_W-1:0]  pg_cfg;
    logic [1:0]               pg_active_q, pg_active_d;
    logic [1:0][PULSE_W-1:0]  pg_ms_q, pg_ms_d;
    logic [1:0][PRE_W-1:0]    pg_pre_q, pg_pre_d;

    assign pg_start  = {galvo_start, cam_start};
    assign pg_cancel = iABORT && (state_q != StIdle);
    assign pg_cfg    = {galvo_ms_q, cam_ms_q};

    always_comb begin
        pg_active_d = pg_active_q;
        pg_ms_d     = pg_ms_q;
        pg_pre_d    = pg_pre_q;
        for (int i = 0; i < 2; i++) begin
            if (pg_cancel) begin
                pg_active_d[i] = 1'b0;
            end else if (pg_start[i]) begin
                pg_active_d[i] = (pg_cfg[i] != '0);
                pg_ms_d[i]     = pg_cfg[i];
                pg_pre_d[i]    = '0;
            end else if (pg_active_q[i]) begin
                if (pg_pre_q[i] == PRE_LAST) begin
                    pg_pre_d[i] = '0;
                    if (pg_ms_q[i] == PULSE_W'(1)) begin
                        pg_active_d[i] = 1'b0;
                    end else begin
                        pg_ms_d[i] = pg_ms_q[i] - PULSE_W'(1);
                    end
                end else begin
                    pg_pre_d[i] = pg_pre_q[i] + PRE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pg_active_q <= '0;
            pg_ms_q     <= '0;
            pg_pre_q    <= '0;
        end else begin
            pg_active_q <= pg_active_d;
            pg_ms_q     <= pg_ms_d;
            pg_pre_q    <= pg_pre_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oCAMERA_TRIGGER       = pg_active_q[0];
    assign oGALVO_CHANGE_TRIGGER = pg_active_q[1];
    assign oFRAME_ID             = img_q;
    assign oPOSITION_ID          = pos_q;
    assign oBUSY                 = (state_q != StIdle);
    assign oDONE                 = (state_q == StDone);
    assign oERR_ZERO_CFG         = err_q;

endmodule

// File: tb/tb_slm_acq_sequencer_multi.sv
// Directed bench for slm_acq_sequencer_multi: CLK_HZ=10000 (1 ms = 10 cycles),
// SYNC_FILTER=2, frame sync period 100 cycles (50 high, 50 low).
module tb_slm_acq_sequencer_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mode_galvo, mode_loop, abort_req;
    logic [6:0]  num_img;
    logic [15:0] num_cyc;
    logic [31:0] num_pos;
    logic [3:0]  settle;
    logic [7:0]  cam_ms, galvo_ms;
    logic        galvo_ack;
    logic        vsync;
    logic        cam_trig, galvo_trig;
    logic [6:0]  frame_id;
    logic [31:0] pos_id;
    logic        busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    bit glitch_en = 1'b0;
    bit ack_en    = 1'b0;
    bit chk_ack   = 1'b0;
    bit ok;

    // monitor state
    int cyc_n = 0;
    int cam_cnt, galvo_cnt, done_cyc, err_cyc, cam_early;
    int cam_len, galvo_len, cam_t, done_t;
    int cam_w[$], galvo_w[$], cam_fid[$], cam_pid[$];
    bit cam_prev = 1'b0, galvo_prev = 1'b0, vsync_prev = 1'b0;
    bit ack_seen = 1'b0, fall_seen = 1'b0;

    int exp_ng_fid [3] = '{0, 1, 2};
    int exp_g_fid  [6] = '{0, 1, 0, 1, 0, 1};
    int exp_g_pid  [6] = '{0, 0, 1, 1, 2, 2};
    int exp_l_fid  [5] = '{0, 1, 0, 1, 0};

    slm_acq_sequencer_multi #(
        .IMG_W       (7),
        .CYC_W       (16),
        .POS_W       (32),
        .PULSE_W     (8),
        .CLK_HZ      (10000),
        .SYNC_FILTER (2)
    ) dut (
        .iCLK                  (clk),
        .iRST                  (rst),
        .iSTART                (start),
        .iMODE_GALVO           (mode_galvo),
        .iMODE_LOOP            (mode_loop),
        .iABORT                (abort_req),
        .iNUM_IMAGES           (num_img),
        .iCYCLES_PER_IMAGE     (num_cyc),
        .iNUM_POSITIONS        (num_pos),
        .iSETTLE_FRAMES        (settle),
        .iCAM_PULSE_MS         (cam_ms),
        .iGALVO_PULSE_MS       (galvo_ms),
        .iGALVO_ACK            (galvo_ack),
        .iVGA_FRAME_SYNC       (vsync),
        .oCAMERA_TRIGGER       (cam_trig),
        .oGALVO_CHANGE_TRIGGER (galvo_trig),
        .oFRAME_ID             (frame_id),
        .oPOSITION_ID          (pos_id),
        .oBUSY                 (busy),
        .oDONE                 (done),
        .oERR_ZERO_CFG         (err)
    );

    always #5 clk = ~clk;

    // Frame sync: 50 cycles high, 50 low; optional 1-cycle low glitch mid-high.
    initial begin
        vsync = 1'b0;
        forever begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                vsync = (i < 50) && !(glitch_en && i == 25);
            end
        end
    end

    // Galvo acknowledge 37 cycles after each galvo pulse starts.
    always @(posedge galvo_trig) begin
        if (ack_en) begin
            repeat (37) @(negedge clk);
            galvo_ack = 1'b1;
            @(negedge clk);
            galvo_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (cam_trig && !cam_prev) begin
            cam_cnt++;
            cam_fid.push_back(int'(frame_id));
            cam_pid.push_back(int'(pos_id));
            cam_t = cyc_n;
            if (!fall_seen || (chk_ack && !ack_seen)) cam_early++;
            fall_seen = 1'b0;
        end
        if (cam_trig) cam_len = cam_prev ? cam_len + 1 : 1;
        else if (cam_prev) cam_w.push_back(cam_len);
        cam_prev = cam_trig;

        if (galvo_trig && !galvo_prev) begin
            galvo_cnt++;
            ack_seen  = 1'b0;
            fall_seen = 1'b0;
        end
        if (galvo_trig) galvo_len = galvo_prev ? galvo_len + 1 : 1;
        else if (galvo_prev) galvo_w.push_back(galvo_len);
        galvo_prev = galvo_trig;

        if (galvo_ack) ack_seen = 1'b1;
        if (!vsync && vsync_prev) fall_seen = 1'b1;
        vsync_prev = vsync;
        if (done) begin
            done_cyc++;
            done_t = cyc_n;
        end
        if (err) err_cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cam_cnt = 0; galvo_cnt = 0; done_cyc = 0; err_cyc = 0; cam_early = 0;
        cam_t = 0; done_t = 0;
        cam_w.delete(); galvo_w.delete(); cam_fid.delete(); cam_pid.delete();
    endtask

    task automatic start_run(input bit g, input bit l, input int ni, input int nc, input int np,
                             input int st, input int cms, input int gms);
        @(posedge vsync);
        @(negedge clk);
        #1;
        clear_mon();
        mode_galvo = g;
        mode_loop  = l;
        num_img    = 7'(ni);
        num_cyc    = 16'(nc);
        num_pos    = 32'(np);
        settle     = 4'(st);
        cam_ms     = 8'(cms);
        galvo_ms   = 8'(gms);
        start      = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit res);
        res = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                res = 1'b1;
                break;
            end
        end
    endtask

    task automatic zero_case(input string tag, input bit g, input int ni, input int nc,
                             input int np);
        start_run(g, 1'b0, ni, nc, np, 1, 1, 1);
        repeat (5) @(negedge clk);
        #1;
        check({tag, "_err_pulse"}, err_cyc, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cam"}, cam_cnt, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode_galvo = 1'b0; mode_loop = 1'b0; abort_req = 1'b0;
        num_img = '0; num_cyc = '0; num_pos = '0; settle = '0;
        cam_ms = '0; galvo_ms = '0; galvo_ack = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, cam_trig, galvo_trig, done, err}, 0);
        check("reset_ids", {frame_id, pos_id}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // zero configurations are rejected
        zero_case("zero_img", 1'b0, 0, 2, 0);
        zero_case("zero_pos", 1'b1, 1, 1, 0);
        zero_case("zero_cyc", 1'b0, 2, 0, 0);

        // non-galvo single pass, plus a start while busy
        start_run(1'b0, 1'b0, 3, 2, 0, 1, 2, 0);
        repeat (250) @(negedge clk);
        #1;
        num_img = 7'd5;
        start   = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle(3000, ok);
        check("ng_finish", ok, 1);
        repeat (2) @(negedge clk);
        #1;
        check("ng_done", done_cyc, 1);
        check("ng_cam_cnt", cam_cnt, 3);
        check("ng_galvo_cnt", galvo_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ng_fid%0d", i), (i < cam_fid.size()) ? cam_fid[i] : -1,
                  exp_ng_fid[i]);
            check($sformatf("ng_cam_w%0d", i), (i < cam_w.size()) ? cam_w[i] : -1, 20);
        end
        check("ng_idle_fid", frame_id, 0);
        check("ng_idle_busy", busy, 0);

        // galvo mode, 2 images x 3 positions
        ack_en  = 1'b1;
        chk_ack = 1'b1;
        start_run(1'b1, 1'b0, 2, 1, 3, 1, 1, 1);
        wait_idle(6000, ok);
        check("g_finish", ok, 1);
        repeat (2) @(negedge clk);
        #1;
        check("g_galvo_cnt", galvo_cnt, 3);
        check("g_cam_cnt", cam_cnt, 6);
        check("g_order", cam_early, 0);
        check("g_done", done_cyc, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("g_galvo_w%0d", i), (i < galvo_w.size()) ? galvo_w[i] : -1, 10);
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("g_fid%0d", i), (i < cam_fid.size()) ? cam_fid[i] : -1,
                  exp_g_fid[i]);
            check($sformatf("g_pid%0d", i), (i < cam_pid.size()) ? cam_pid[i] : -1,
                  exp_g_pid[i]);
        end
        check("g_idle_pid", pos_id, 0);
        ack_en  = 1'b0;
        chk_ack = 1'b0;

        // galvo mode with no ack: hangs in settle until abort
        start_run(1'b1, 1'b0, 1, 1, 1, 1, 1, 200);
        repeat (500) @(negedge clk);
        #1;
        check("ab_no_cam", cam_cnt, 0);
        check("ab_busy", busy, 1);
        check("ab_galvo_high", galvo_trig, 1);
        abort_req = 1'b1;
        @(posedge clk);
        #1;
        check("ab_idle", busy, 0);
        check("ab_galvo_low", galvo_trig, 0);
        check("ab_cam_low", cam_trig, 0);
        @(negedge clk);
        #1;
        abort_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("ab_no_done", done_cyc, 0);

        // loop mode, abort after the 5th camera pulse starts
        start_run(1'b0, 1'b1, 2, 1, 0, 1, 1, 0);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (cam_cnt >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("lp_reach5", ok, 1);
        abort_req = 1'b1;
        @(posedge clk);
        #1;
        check("lp_idle", busy, 0);
        check("lp_cam_low", cam_trig, 0);
        @(negedge clk);
        #1;
        abort_req = 1'b0;
        check("lp_no_done", done_cyc, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lp_fid%0d", i), (i < cam_fid.size()) ? cam_fid[i] : -1,
                  exp_l_fid[i]);
        end

        // glitchy sync: display of 3 frames must still take 3 full periods
        glitch_en = 1'b1;
        start_run(1'b0, 1'b0, 1, 3, 0, 1, 1, 0);
        wait_idle(3000, ok);
        check("gl_finish", ok, 1);
        check("gl_done", done_cyc, 1);
        check("gl_span", done_t - cam_t, 300);
        glitch_en = 1'b0;

        // asynchronous reset in the middle of a camera pulse
        start_run(1'b0, 1'b0, 1, 1, 0, 1, 10, 0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (cam_trig) begin
                ok = 1'b1;
                break;
            end
        end
        check("rs_cam_seen", ok, 1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rs_cam_low", cam_trig, 0);
        check("rs_busy", busy, 0);
        check("rs_fid", frame_id, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rs_no_done", done_cyc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
